signed_seq_divider: RTL and testbench

//   Multi-cycle signed integer divider; the division side of the multdiv unit, companion to the

---
 rtl/signed_seq_divider_pkg.sv | 17 +
 rtl/signed_seq_divider_div_step.sv | 26 ++
 rtl/signed_seq_divider.sv | 143 ++++++++++++++
 tb/tb_signed_seq_divider.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_seq_divider_pkg.sv
// Shared definitions for the signed sequential divider: FSM state encoding,
// default operand width and step-counter sizing.
package signed_seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, emit the quotient bit.
module signed_seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // The incoming remainder is always below |B| <= 2^(WIDTH-1), so the shifted
  // value fits in WIDTH bits and bit WIDTH of the difference is the borrow.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign w_ge    = ~w_diff[WIDTH];

  assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, quotient
// truncated toward zero, remainder carries the dividend's sign.
module signed_seq_divider
  import signed_seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned      CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN      = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_exc;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exception;
  logic             r_rdy;
  logic             r_busy;

  logic             w_start;
  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  // |MIN| wraps to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign w_mag_a  = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
  assign w_mag_b  = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;
  assign w_b_zero = (data_operandB == '0);
  assign w_ovf    = (data_operandA == MIN) && (data_operandB == '1);

  signed_seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_DIV) begin
          w_start     = 1'b1;
          w_state_nxt = w_b_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_exc       <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_sign_a <= data_operandA[WIDTH-1];
            r_sign_b <= data_operandB[WIDTH-1];
            r_div    <= w_mag_b;
            r_exc    <= w_b_zero | w_ovf;
            // Divide-by-zero preloads |A| as the remainder so the common
            // sign fix-up reproduces A and a zero quotient.
            if (w_b_zero) begin
              r_rem <= w_mag_a;
              r_quo <= '0;
            end else begin
              r_rem <= '0;
              r_quo <= w_mag_a;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_ONE;
        end
        S_FIX: begin
          r_result    <= (r_sign_a ^ r_sign_b) ? (~r_quo + ONE) : r_quo;
          r_remainder <= r_sign_a ? (~r_rem + ONE) : r_rem;
          r_exception <= r_exc;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (WIDTH=32): directed corner cases
// plus randomized operands against a plain-arithmetic reference model.
module tb_signed_seq_divider;

  logic        clock;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  signed_seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input int a, input int b,
                                output int q, output int r, output bit e);
    if (b == 0) begin
      q = 0; r = a; e = 1'b1;
    end else if (a == int'(32'h8000_0000) && b == -1) begin
      q = a; r = 0; e = 1'b1;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
  endfunction

  // Launch one op (accepting edge E0) and wait for RDY; edges = index of the
  // edge after which RDY was seen (or the bound if it never came).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int edges);
    @(negedge clock);
    ctrl_DIV = 1'b1; opA = a; opB = b;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; opA = $urandom; opB = $urandom;
    edges = 0;
    while (!data_resultRDY && edges < 200) begin
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ctrl_DIV = 1'b0; opA = '0; opB = '0;
    #12;
    checks++;
    if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_remainder, data_exception, data_resultRDY, busy);
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_signs;
    int a_t [4] = '{100, -100, 100, -100};
    int b_t [4] = '{7, 7, -7, -7};
    int q_t [4] = '{14, -14, -14, 14};
    int r_t [4] = '{2, -2, 2, -2};
    int edges;
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], edges);
      checks++;
      if (edges !== 33) begin
        errors++; $display("FAIL sign_latency[%0d]: got %0d edges, want 33", i, edges);
      end
      checks++;
      if (data_result !== q_t[i] || data_remainder !== r_t[i] || data_exception !== 1'b0) begin
        errors++;
        $display("FAIL sign_result[%0d]: got q=%0d r=%0d e=%b, want q=%0d r=%0d e=0", i,
                 $signed(data_result), $signed(data_remainder), data_exception, q_t[i], r_t[i]);
      end
      @(posedge clock); #1;
      checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rdy_pulse[%0d]: got rdy=%b busy=%b, want 0 0", i, data_resultRDY, busy);
      end
    end
  endtask

  task automatic test_div_zero;
    int edges;
    run_op(32'd7, 32'd0, edges);
    checks++;
    if (edges !== 1) begin
      errors++; $display("FAIL divzero_latency: got %0d edges, want 1", edges);
    end
    checks++;
    if (data_result !== 32'd0 || data_remainder !== 32'd7 || data_exception !== 1'b1) begin
      errors++;
      $display("FAIL divzero_result: got q=%h r=%h e=%b, want q=0 r=7 e=1",
               data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_overflow;
    int edges;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, edges);
    checks++;
    if (edges !== 33 || data_result !== 32'h8000_0000 || data_remainder !== 32'd0 ||
        data_exception !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got edges=%0d q=%h r=%h e=%b, want 33 80000000 0 1",
               edges, data_result, data_remainder, data_exception);
    end
    run_op(32'h8000_0000, 32'd1, edges);
    checks++;
    if (data_result !== 32'h8000_0000 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL min_div_one: got q=%h r=%h e=%b, want 80000000 0 0",
               data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    @(negedge clock);
    ctrl_DIV = 1'b1; opA = 32'd100; opB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    edges = 0;
    while (!data_resultRDY && edges < 200) begin
      if (edges == 9) begin
        ctrl_DIV = 1'b1; opA = 32'd9; opB = 32'd3;
      end else begin
        ctrl_DIV = 1'b0;
      end
      @(posedge clock); #1;
      edges++;
      if (edges == 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL busy_mid_op: got %b, want 1", busy);
        end
      end
    end
    ctrl_DIV = 1'b0;
    checks++;
    if (edges !== 33 || data_result !== 32'd14 || data_remainder !== 32'd2) begin
      errors++;
      $display("FAIL ignore_while_busy: got edges=%0d q=%0d r=%0d, want 33 14 2",
               edges, data_result, data_remainder);
    end
    // Still inside the RDY cycle: a start here must be accepted.
    ctrl_DIV = 1'b1; opA = 32'd9; opB = 32'd3;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; opA = $urandom; opB = $urandom;
    edges = 0;
    while (!data_resultRDY && edges < 200) begin
      @(posedge clock); #1;
      edges++;
    end
    checks++;
    if (edges !== 33 || data_result !== 32'd3 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL start_in_rdy: got edges=%0d q=%0d r=%0d e=%b, want 33 3 0 0",
               edges, data_result, data_remainder, data_exception);
    end
  endtask

  task automatic test_reset_mid_op;
    int edges;
    bit saw_rdy;
    @(negedge clock);
    ctrl_DIV = 1'b1; opA = 32'd100; opB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (16) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got res=%h rem=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_remainder, data_exception, data_resultRDY, busy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    saw_rdy = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) saw_rdy = 1'b1;
    end
    checks++;
    if (saw_rdy !== 1'b0) begin
      errors++; $display("FAIL no_rdy_after_abort: got rdy pulse, want none");
    end
    run_op(32'd100, 32'd7, edges);
    checks++;
    if (edges !== 33 || data_result !== 32'd14 || data_remainder !== 32'd2) begin
      errors++;
      $display("FAIL op_after_reset: got edges=%0d q=%0d r=%0d, want 33 14 2",
               edges, data_result, data_remainder);
    end
  endtask

  task automatic test_random;
    int a, b, q, r, edges, want_edges;
    bit e;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       begin a = int'($urandom); b = 0; end
        1:       begin a = int'(32'h8000_0000); b = -1; end
        2:       begin a = int'($urandom_range(0, 400)) - 200; b = int'($urandom_range(0, 20)) - 10; end
        3:       begin a = int'($urandom); b = int'($urandom_range(0, 6)) - 3; end
        default: begin a = int'($urandom); b = int'($urandom) >>> $urandom_range(0, 30); end
      endcase
      model(a, b, q, r, e);
      want_edges = (b == 0) ? 1 : 33;
      run_op(a, b, edges);
      checks++;
      if (edges !== want_edges) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d edges, want %0d", i, edges, want_edges);
      end
      checks++;
      if (data_result !== q || data_remainder !== r || data_exception !== e) begin
        errors++;
        $display("FAIL rand_result[%0d] %0d/%0d: got q=%0d r=%0d e=%b, want q=%0d r=%0d e=%b",
                 i, a, b, $signed(data_result), $signed(data_remainder), data_exception, q, r, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_signs;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
